sram_readback_streamer: RTL and testbench
=========================================

# sram_readback_streamer

Parametrised readback engine for the JPEG pipeline's output SRAM. It replaces fixed-delay bulk memory dumps with a start/done-controlled sequencer. On `start` it reads `word_count` consecutive words from `base_addr` through a synchronous SRAM read port and presents them on a valid/ready stream with full backpressure. It sits between the 2D-DCT output memory and the downstream consumer (entropy coder or bench file writer).

## Interface
Parameters:
- `DATA_W`, 64: SRAM word width.
- `ADDR_W`, 15: SRAM address width; depth is 2^ADDR_W (32768 words).
- `RD_LAT`, 1: SRAM read latency in cycles; legal values are 1 or 2.
- `FIFO_DEPTH`, 4: output buffer depth; must be a power of 2 and ≥ RD_LAT+2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; ignored while `busy`=1.
- `base_addr`  in  ADDR_W  first word address; sampled on `start`.
- `word_count`  in  ADDR_W+1  number of words to read, 0..2^ADDR_W; sampled on `start`.
- `busy`  out  1  high from the cycle after `start` until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse when the transfer is complete.
- `mem_en`  out  1  SRAM read enable.
- `mem_addr`  out  ADDR_W  SRAM read address.
- `mem_rdata`  in  DATA_W  SRAM read data, valid RD_LAT cycles after `mem_en`.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  stream consumer ready.
- `out_data`  out  DATA_W  stream data.
- `out_last`  out  1  high together with the final word of the transfer.
- `checksum`  out  DATA_W  present only with CHECKSUM_EN.

## Operation
- FSM states:
  - IDLE → RUN on `start` when `word_count`≠0.
  - IDLE → DONE on `start` when `word_count`=0.
  - RUN → DRAIN after the last read is issued.
  - DRAIN → DONE after the last word handshakes.
  - DONE → IDLE unconditionally, after one cycle.
- Read issue: `mem_en`=1 in a cycle only if in RUN and (reads in flight + FIFO occupancy) < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
- Addressing: `mem_addr` starts at `base_addr` and increments by 1 per issued read, wrapping modulo 2^ADDR_W. With `word_count`=2^ADDR_W, every word is read exactly once.
- Read data passes through an RD_LAT-deep valid shift register and is written into a show-ahead FIFO.
- Handshake: a transfer occurs when `out_valid`&&`out_ready`.
  - Once `out_valid` is asserted, it holds, and `out_data` and `out_last` stay stable until the handshake.
- A remaining-word counter (ADDR_W+1 bits) drives `out_last`; it decrements per handshake.
- `start` while `busy`=1 is ignored; there is no queueing and no effect.
- `reset` mid-transfer: the next cycle is IDLE, the FIFO is empty, in-flight reads are discarded, and `done` does not pulse.
- Reset values: `busy`=0, `done`=0, `mem_en`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `checksum`=0.

## Timing
- `start` high in cycle 0:
  - `busy` and the first `mem_en` are high in cycle 1.
  - Data is returned in cycle 1+RD_LAT.
  - `out_valid` rises in cycle 2+RD_LAT (cycle 3 for RD_LAT=1).
- With `out_ready` held high: one word per cycle sustained, no bubbles. An N-word transfer ends its last handshake in cycle N+1+RD_LAT.
- `done` pulses in the cycle after the last handshake. `busy` falls in the cycle after `done`.
- `word_count`=0: `done` in cycle 1, no `mem_en`, no `out_valid`.
- When `out_ready` deasserts, at most FIFO_DEPTH words are fetched ahead. Reads resume the cycle after a credit frees.

## Configuration
- `SRAM_READBACK_CHECKSUM_EN` defined:
  - Adds output `checksum`, the DATA_W-bit XOR of every word handshaken in the current transfer.
  - `checksum` clears to 0 in the cycle after `start` is accepted, and holds its final value from `done` until the next `start`.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- `base_addr`=0x0010, `word_count`=8, memory word k = k, `out_ready`=1 → `out_data` 0x10..0x17 on consecutive cycles from cycle 3; `out_last` only on 0x17; `done` in cycle 11.
- `base_addr`=0x7FFE, `word_count`=4 → `mem_addr` sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001; data is in the same order.
- `out_ready` toggling 1,0,0,1 repeatedly, RD_LAT=2, `word_count`=16 → no lost or duplicated words; data stays stable while stalled; outstanding reads never exceed FIFO_DEPTH.
- `word_count`=0 → `done` in cycle 1, `mem_en` never asserted; a second `start` during `busy` has no effect.
- `reset` asserted in cycle 5 of a 32-word transfer → outputs return to their reset values the next cycle; no `done`; a new `start` then completes normally.
- With CHECKSUM_EN defined, words 0x1, 0x2, 0x4, 0x8 → `checksum`=0xF at `done`.

Source files
------------

// File: rtl/sram_readback_streamer.sv
// Start/done sequencer that streams word_count SRAM words from base_addr onto a valid/ready port.
// Optional running XOR output `checksum` is enabled by defining SRAM_READBACK_CHECKSUM_EN.
module sram_readback_streamer #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
`ifdef SRAM_READBACK_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   issue_left_q, issue_left_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

   logic [CNT_W-1:0]  inflight;
   logic              credit_ok;
   logic              start_acc;
   logic              issue;
   logic              fifo_we;
   logic              hs;

`ifdef SRAM_READBACK_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

   // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
         inflight = inflight + CNT_W'(vld_sr_q[i]);
      end
      // A read may only issue if its word is guaranteed a FIFO slot on arrival.
      credit_ok = ({1'b0, inflight} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_DEPTH);
      start_acc = start && (state_q == S_IDLE);
      issue     = (state_q == S_RUN) && credit_ok;
      fifo_we   = vld_sr_q[RD_LAT-1];

      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      mem_en    = issue;
      mem_addr  = addr_q;
      out_valid = (count_q != '0);
      out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
      out_last  = out_valid && (remain_q == (ADDR_W + 1)'(1));
      hs        = out_valid && out_ready;

      vld_sr_d = '0;
      vld_sr_d[0] = issue;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         vld_sr_d[i] = vld_sr_q[i-1];
      end

      wr_ptr_d = fifo_we ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = hs ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(fifo_we) - CNT_W'(hs);

      state_d      = state_q;
      addr_d       = issue ? addr_q + ADDR_W'(1) : addr_q;
      issue_left_d = issue ? issue_left_q - (ADDR_W + 1)'(1) : issue_left_q;
      remain_d     = hs ? remain_q - (ADDR_W + 1)'(1) : remain_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d       = base_addr;
               issue_left_d = word_count;
               remain_d     = word_count;
               state_d      = (word_count == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (issue && (issue_left_q == (ADDR_W + 1)'(1))) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (hs && (remain_q == (ADDR_W + 1)'(1))) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef SRAM_READBACK_CHECKSUM_EN
      checksum_d = checksum_q;
      if (start_acc) checksum_d = '0;
      else if (hs)   checksum_d = checksum_q ^ out_data;
      checksum = checksum_q;
`endif
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         remain_q     <= '0;
         vld_sr_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
`ifdef SRAM_READBACK_CHECKSUM_EN
         checksum_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         remain_q     <= remain_d;
         vld_sr_q     <= vld_sr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
`ifdef SRAM_READBACK_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   // NOTE: FIFO storage is not reset; occupancy gating keeps stale entries invisible.
   always_ff @(posedge clk) begin
      if (fifo_we) fifo_mem_q[wr_ptr_q] <= mem_rdata;
   end

endmodule

// File: tb/tb_sram_readback_streamer.sv
// Randomized scoreboard bench for sram_readback_streamer with a behavioural SRAM and stream model.
// Define SRAM_READBACK_CHECKSUM_EN to also check the XOR checksum output.
module tb_sram_readback_streamer;

   localparam int DATA_W     = 64;
   localparam int ADDR_W     = 15;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int MEM_WORDS  = 1 << ADDR_W;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   word_count = '0;
   logic              busy, done, mem_en, out_valid, out_last;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata, out_data;
   logic              out_ready = 1'b0;
`ifdef SRAM_READBACK_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   sram_readback_streamer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .busy(busy), .done(done), .mem_en(mem_en),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef SRAM_READBACK_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural SRAM: data for a read appears RD_LAT cycles later, junk otherwise.
   logic [DATA_W-1:0] sram [MEM_WORDS];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_en ? sram[mem_addr] : {$urandom, $urandom};
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   // Consumer: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
   int rdy_mode = 0;
   int pat_idx  = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = (pat_idx == 0) || (pat_idx == 3);
            pat_idx   = (pat_idx + 1) % 4;
         end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Scoreboard queues filled by stimulus, drained by the monitor.
   exp_t              exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   int                issued_cnt = 0;
   int                hs_cnt = 0;
   int                first_hs_cyc = -1;
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (mem_en) begin
            issued_cnt++;
            if (addr_q.size() == 0) check("spurious_mem_en", 64'(mem_en), 64'(0));
            else                    check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
         end
         if (prev_stall) begin
            check("stall_valid_held", 64'(out_valid), 64'(1));
            check("stall_data_stable", out_data, prev_data);
            check("stall_last_stable", 64'(out_last), 64'(prev_last));
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'(out_valid), 64'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_data", out_data, e.data);
               check("out_last", 64'(out_last), 64'(e.last));
            end
         end
         if (mem_en) check("outstanding_le_depth", 64'((issued_cnt - hs_cnt) <= FIFO_DEPTH), 64'(1));
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_mem_en"}, 64'(mem_en), 64'(0));
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_out_data"}, out_data, 64'(0));
      check({tag, "_out_last"}, 64'(out_last), 64'(0));
`ifdef SRAM_READBACK_CHECKSUM_EN
      check({tag, "_checksum"}, checksum, 64'(0));
`endif
   endtask

   task automatic fill_index();
      for (int a = 0; a < MEM_WORDS; a++) sram[a] = DATA_W'(a);
   endtask

   task automatic fill_random();
      for (int a = 0; a < MEM_WORDS; a++) sram[a] = {$urandom, $urandom};
   endtask

   // Expected stream: n consecutive words from base, modulo the address space.
   task automatic load_expect(input logic [ADDR_W-1:0] base, input int n, output logic [DATA_W-1:0] chk);
      logic [ADDR_W-1:0] a;
      exp_t e;
      chk = '0;
      for (int i = 0; i < n; i++) begin
         a      = ADDR_W'(int'(base) + i);
         e.data = sram[a];
         e.last = (i == n - 1);
         chk    = chk ^ e.data;
         exp_q.push_back(e);
         addr_q.push_back(a);
      end
      issued_cnt   = 0;
      hs_cnt       = 0;
      first_hs_cyc = -1;
   endtask

   task automatic run_xfer(input logic [ADDR_W-1:0] base, input int n, input int mode, input bit timed);
      logic [DATA_W-1:0] chk;
      int c0, k, k_done, budget;
      load_expect(base, n, chk);
      rdy_mode = mode;
      budget   = 8 * n + 64;
      k_done   = -1;
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; word_count = (ADDR_W + 1)'(n);
      c0 = cyc;
      @(posedge clk); #1;
      base_addr = ~base; word_count = (ADDR_W + 1)'(5);   // held start while busy must be ignored
      for (k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("busy_cycle1", 64'(busy), 64'(1));
            check("mem_en_cycle1", 64'(mem_en), 64'(n != 0));
`ifdef SRAM_READBACK_CHECKSUM_EN
            check("checksum_cleared", checksum, 64'(0));
`endif
         end
         if (done) begin
            k_done = cyc - c0;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("done_seen", 64'(k_done >= 0), 64'(1));
      if (k_done >= 0) begin
         if (timed) begin
            check("done_cycle", 64'(k_done), 64'((n == 0) ? 1 : n + 2 + RD_LAT));
            if (n != 0) check("first_valid_cycle", 64'(first_hs_cyc - c0), 64'(2 + RD_LAT));
         end
         check("words_left", 64'(exp_q.size()), 64'(0));
         check("reads_left", 64'(addr_q.size()), 64'(0));
`ifdef SRAM_READBACK_CHECKSUM_EN
         check("checksum_at_done", checksum, chk);
`endif
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_done", 64'(busy), 64'(0));
      check("done_one_cycle", 64'(done), 64'(0));
`ifdef SRAM_READBACK_CHECKSUM_EN
      check("checksum_held", checksum, chk);
`endif
      exp_q.delete();
      addr_q.delete();
   endtask

   initial begin
      logic [DATA_W-1:0] chk;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      fill_index();
      run_xfer(15'h0010, 8, 0, 1'b1);
      run_xfer(15'h7FFE, 4, 0, 1'b1);
      run_xfer(15'h0000, 0, 0, 1'b1);
      run_xfer(15'h1234, 1, 0, 1'b1);

      fill_random();
      run_xfer(15'(($urandom)), 16, 1, 1'b0);

      // Reset in cycle 5 of a 32-word transfer, then a fresh transfer.
      load_expect(15'h0200, 32, chk);
      rdy_mode = 0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 15'h0200; word_count = 16'd32;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_values("midreset");
      exp_q.delete();
      addr_q.delete();
      repeat (8) begin
         @(negedge clk);
         check("no_done_after_reset", 64'(done), 64'(0));
         check("no_busy_after_reset", 64'(busy), 64'(0));
      end
      run_xfer(15'h0200, 32, 2, 1'b0);

      sram[15'h0100] = 64'h1;
      sram[15'h0101] = 64'h2;
      sram[15'h0102] = 64'h4;
      sram[15'h0103] = 64'h8;
      run_xfer(15'h0100, 4, 0, 1'b1);

      for (int r = 0; r < 10; r++) begin
         int mode;
         mode = $urandom_range(0, 2);
         run_xfer(15'($urandom), $urandom_range(1, 40), mode, mode == 0);
      end

      run_xfer(15'(($urandom)), MEM_WORDS, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
